delay_timer_arbiter: RTL



---
 rtl/delay_timer_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/delay_timer_arbiter.sv
// Round-robin arbiter that lends one shared modulo counter to N_REQ delay users.
// Each winner gets (len+1) enabled ticks, then a one-cycle done pulse.
module delay_timer_arbiter #(
    parameter int N_REQ = 4,
    parameter int DW    = 16,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*DW-1:0]   len,
    input  logic                  tick_en,
    input  logic                  abort,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      done,
    output logic                  busy,
    output logic [IW-1:0]         cur_id,
    output logic [DW-1:0]         cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]    LAST_ID  = IW'(N_REQ - 1);

    state_t          state;
    logic [DW-1:0]   max_r;
    logic [IW-1:0]   rr_ptr;
    logic [DW-1:0]   len_arr [N_REQ];
    logic            pick_vld;
    logic [IW-1:0]   pick_id;
    logic [IW-1:0]   rr_next;
    int              idx;

    for (genvar i = 0; i < N_REQ; i++) begin : g_len
        assign len_arr[i] = len[i*DW +: DW];
    end

    // Scan downward in priority distance so the nearest requester at/after rr_ptr wins last.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        idx      = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (req[idx]) begin
                pick_vld = 1'b1;
                pick_id  = IW'(idx);
            end
        end
    end

    assign rr_next = (pick_id == LAST_ID) ? '0 : pick_id + IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            gnt    <= '0;
            done   <= '0;
            busy   <= 1'b0;
            cur_id <= '0;
            cnt    <= '0;
            rr_ptr <= '0;
            max_r  <= '0;
        end else begin
            gnt  <= '0;
            done <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        gnt    <= ONE_HOT0 << pick_id;
                        cur_id <= pick_id;
                        max_r  <= len_arr[pick_id];
                        cnt    <= '0;
                        rr_ptr <= rr_next;
                    end
                end
                RUN: begin
                    // abort beats a coincident terminal tick: the job is dropped silently
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (tick_en) begin
                        if (cnt == max_r) begin
                            state <= DONE;
                            cnt   <= '0;
                            done  <= ONE_HOT0 << cur_id;
                        end else begin
                            cnt <= cnt + DW'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
